// File: rtl/tone_sequencer.sv
// Multi-voice square-wave melody player: fetches {last, duration, half-periods}
// entries from a synchronous note ROM and streams the mixed sample to a codec.
module tone_sequencer #(
    parameter int NUM_CH    = 2,
    parameter int ADDR_W    = 8,
    parameter int HALF_W    = 19,
    parameter int DUR_W     = 24,
    parameter int SAMPLE_W  = 32,
    parameter int AMPLITUDE = 10000000
) (
    input  logic                               rate_divider_clock,
    input  logic                               reset,
    input  logic                               start,
    input  logic                               stop,
    input  logic                               loop_en,
    input  logic [ADDR_W-1:0]                  base_addr,
    output logic [ADDR_W-1:0]                  rom_addr,
    input  logic [DUR_W+NUM_CH*HALF_W:0]       rom_q,
    input  logic                               audio_out_allowed,
    output logic                               write_audio_out,
    output logic signed [SAMPLE_W-1:0]         left_sample,
    output logic signed [SAMPLE_W-1:0]         right_sample,
    output logic                               busy,
    output logic                               done,
    output logic [2:0]                         state_dbg
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        PLAY  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic signed [SAMPLE_W-1:0] AMP = SAMPLE_W'(AMPLITUDE);
    localparam longint MIX_PEAK  = longint'(NUM_CH) * longint'(AMPLITUDE);
    localparam longint MIX_LIMIT = 64'sd1 <<< (SAMPLE_W - 1);

    // The mixer does not saturate, so the worst-case sum must fit the sample.
    generate
        if (MIX_PEAK >= MIX_LIMIT) begin : g_mix_range
            $error("tone_sequencer: NUM_CH*AMPLITUDE overflows SAMPLE_W");
        end
    endgenerate

    state_t state_q, state_d;

    logic [HALF_W-1:0]          half_q [NUM_CH];
    logic [HALF_W-1:0]          cnt_q  [NUM_CH];
    logic [HALF_W-1:0]          cnt_d  [NUM_CH];
    logic [NUM_CH-1:0]          neg_q, neg_d;
    logic                       last_q;
    logic [DUR_W-1:0]           dur_q;
    logic signed [SAMPLE_W-1:0] sample_q, play_mix, load_mix;

    logic                       rom_last;
    logic [DUR_W-1:0]           rom_dur;
    logic                       dur_end;

    assign rom_last = rom_q[DUR_W+NUM_CH*HALF_W];
    assign rom_dur  = rom_q[DUR_W+NUM_CH*HALF_W-1 -: DUR_W];
    assign dur_end  = (dur_q == DUR_W'(1));

    always_ff @(posedge rate_divider_clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = FETCH;
            FETCH:   state_d = WAIT;
            WAIT:    state_d = PLAY;
            PLAY: begin
                if (dur_end) begin
                    if (!last_q || loop_en) state_d = FETCH;
                    else                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (stop) state_d = IDLE;
    end

    // Next tone state per voice; the sample register is loaded from the
    // post-update phases so each sample lines up with its write strobe.
    always_comb begin
        play_mix = '0;
        load_mix = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            neg_d[i] = neg_q[i];
            if (half_q[i] != '0) begin
                if (cnt_q[i] == half_q[i] - HALF_W'(1)) begin
                    cnt_d[i] = '0;
                    neg_d[i] = ~neg_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + HALF_W'(1);
                end
                play_mix = neg_d[i] ? (play_mix - AMP) : (play_mix + AMP);
            end
            if (rom_q[i*HALF_W +: HALF_W] != '0) load_mix = load_mix + AMP;
        end
    end

    always_ff @(posedge rate_divider_clock) begin
        if (reset) begin
            rom_addr <= '0;
            sample_q <= '0;
            last_q   <= 1'b0;
            dur_q    <= '0;
            neg_q    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                half_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else if (stop) begin
            sample_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) rom_addr <= base_addr;
                end
                WAIT: begin
                    last_q   <= rom_last;
                    dur_q    <= (rom_dur == '0) ? DUR_W'(1) : rom_dur;
                    neg_q    <= '0;
                    sample_q <= load_mix;
                    for (int i = 0; i < NUM_CH; i++) begin
                        half_q[i] <= rom_q[i*HALF_W +: HALF_W];
                        cnt_q[i]  <= '0;
                    end
                end
                PLAY: begin
                    neg_q    <= neg_d;
                    sample_q <= play_mix;
                    for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
                    if (dur_end) begin
                        if (!last_q)      rom_addr <= rom_addr + ADDR_W'(1);
                        else if (loop_en) rom_addr <= base_addr;
                    end else begin
                        dur_q <= dur_q - DUR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign write_audio_out = (state_q == PLAY) && audio_out_allowed;
    assign left_sample     = sample_q;
    assign right_sample    = sample_q;
    assign busy            = (state_q != IDLE);
    assign done            = (state_q == DONE);
    assign state_dbg       = state_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer (two voices) with a one-cycle-latency ROM model.
module tb_tone_sequencer;

    localparam int A = 10000000;

    logic              clk = 1'b0;
    logic              reset, start, stop, loop_en, audio_out_allowed;
    logic [7:0]        base_addr;
    logic [7:0]        rom_addr;
    logic [62:0]       rom_q;
    logic              write_audio_out, busy, done;
    logic signed [31:0] left_sample, right_sample;
    logic [2:0]        state_dbg;
    logic [62:0]       rom_mem [256];

    int vectors = 0;
    int miscompares = 0;

    tone_sequencer dut (
        .rate_divider_clock(clk), .reset(reset), .start(start), .stop(stop),
        .loop_en(loop_en), .base_addr(base_addr), .rom_addr(rom_addr), .rom_q(rom_q),
        .audio_out_allowed(audio_out_allowed), .write_audio_out(write_audio_out),
        .left_sample(left_sample), .right_sample(right_sample), .busy(busy),
        .done(done), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_q <= rom_mem[rom_addr];

    function automatic logic [62:0] mk(input logic last, input int dur, input int h1, input int h0);
        logic [23:0] d;
        logic [18:0] a, b;
        d = 24'(dur);
        a = 19'(h1);
        b = 19'(h0);
        return {last, d, a, b};
    endfunction

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b1; stop = 1'b1; audio_out_allowed = 1'b1;
        tick; tick;
        reset = 1'b0; start = 1'b0; stop = 1'b0;
        vectors++; if (rom_addr !== 8'd0) begin miscompares++; $display("FAIL reset_rom_addr got %0d want 0", rom_addr); end
        vectors++; if (left_sample !== 32'sd0) begin miscompares++; $display("FAIL reset_left got %0d want 0", left_sample); end
        vectors++; if (right_sample !== 32'sd0) begin miscompares++; $display("FAIL reset_right got %0d want 0", right_sample); end
        vectors++; if (write_audio_out !== 1'b0) begin miscompares++; $display("FAIL reset_write got %b want 0", write_audio_out); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
        vectors++; if (state_dbg !== 3'd0) begin miscompares++; $display("FAIL reset_state got %0d want 0", state_dbg); end
        tick;
    endtask

    task automatic test_single_note;
        int exp;
        rom_mem[10] = mk(1'b1, 8, 0, 2);
        base_addr = 8'd10; loop_en = 1'b0; audio_out_allowed = 1'b1;
        start = 1'b1; tick; start = 1'b0;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy got %b want 1", busy); end
        vectors++; if (rom_addr !== 8'd10) begin miscompares++; $display("FAIL single_addr got %0d want 10", rom_addr); end
        vectors++; if (write_audio_out !== 1'b0) begin miscompares++; $display("FAIL single_fetch_write got %b want 0", write_audio_out); end
        tick; tick;
        for (int k = 0; k < 8; k++) begin
            exp = ((k % 4) < 2) ? A : -A;
            vectors++; if (write_audio_out !== 1'b1) begin miscompares++; $display("FAIL single_write k=%0d got %b want 1", k, write_audio_out); end
            vectors++; if (left_sample !== exp) begin miscompares++; $display("FAIL single_left k=%0d got %0d want %0d", k, left_sample, exp); end
            vectors++; if (right_sample !== exp) begin miscompares++; $display("FAIL single_right k=%0d got %0d want %0d", k, right_sample, exp); end
            tick;
        end
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL single_done got %b want 1", done); end
        vectors++; if (write_audio_out !== 1'b0) begin miscompares++; $display("FAIL single_done_write got %b want 0", write_audio_out); end
        tick;
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL single_done_once got %b want 0", done); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_fall got %b want 0", busy); end
    endtask

    task automatic test_two_voice;
        int exp;
        logic wexp;
        rom_mem[20] = mk(1'b0, 4, 0, 2);
        rom_mem[21] = mk(1'b1, 4, 2, 2);
        base_addr = 8'd20; loop_en = 1'b0; audio_out_allowed = 1'b1;
        start = 1'b1; tick; start = 1'b0;
        vectors++; if (rom_addr !== 8'd20) begin miscompares++; $display("FAIL two_addr0 got %0d want 20", rom_addr); end
        tick; tick;
        for (int k = 0; k < 4; k++) begin
            exp = (k < 2) ? A : -A;
            vectors++; if (left_sample !== exp) begin miscompares++; $display("FAIL two_rest_left k=%0d got %0d want %0d", k, left_sample, exp); end
            tick;
        end
        vectors++; if (rom_addr !== 8'd21) begin miscompares++; $display("FAIL two_addr1 got %0d want 21", rom_addr); end
        vectors++; if (write_audio_out !== 1'b0) begin miscompares++; $display("FAIL two_fetch_write got %b want 0", write_audio_out); end
        tick; tick;
        for (int k = 0; k < 4; k++) begin
            wexp = (k != 1);
            audio_out_allowed = wexp;
            #1;
            exp = (k < 2) ? 2 * A : -2 * A;
            vectors++; if (write_audio_out !== wexp) begin miscompares++; $display("FAIL two_write k=%0d got %b want %b", k, write_audio_out, wexp); end
            vectors++; if (left_sample !== exp) begin miscompares++; $display("FAIL two_both_left k=%0d got %0d want %0d", k, left_sample, exp); end
            tick;
        end
        audio_out_allowed = 1'b1;
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL two_done got %b want 1", done); end
        tick;
    endtask

    task automatic test_short_notes;
        int exp;
        rom_mem[30] = mk(1'b0, 3, 1, 0);
        rom_mem[31] = mk(1'b1, 0, 0, 0);
        base_addr = 8'd30; loop_en = 1'b0;
        start = 1'b1; tick; start = 1'b0;
        tick; tick;
        for (int k = 0; k < 3; k++) begin
            exp = (k == 1) ? -A : A;
            vectors++; if (left_sample !== exp) begin miscompares++; $display("FAIL h1_left k=%0d got %0d want %0d", k, left_sample, exp); end
            tick;
        end
        vectors++; if (rom_addr !== 8'd31) begin miscompares++; $display("FAIL h1_next_addr got %0d want 31", rom_addr); end
        tick; tick;
        vectors++; if (left_sample !== 32'sd0) begin miscompares++; $display("FAIL rest_left got %0d want 0", left_sample); end
        vectors++; if (write_audio_out !== 1'b1) begin miscompares++; $display("FAIL dur0_write got %b want 1", write_audio_out); end
        tick;
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL dur0_done got %b want 1", done); end
        tick;
    endtask

    task automatic test_loop_stop;
        logic [7:0] eaddr;
        rom_mem[40] = mk(1'b0, 2, 0, 3);
        rom_mem[41] = mk(1'b0, 2, 0, 3);
        rom_mem[42] = mk(1'b1, 2, 0, 3);
        base_addr = 8'd40; loop_en = 1'b1;
        start = 1'b1; tick; start = 1'b0;
        for (int e = 0; e < 6; e++) begin
            eaddr = 8'(40 + (e % 3));
            vectors++; if (rom_addr !== eaddr) begin miscompares++; $display("FAIL loop_addr e=%0d got %0d want %0d", e, rom_addr, eaddr); end
            for (int c = 0; c < 4; c++) begin
                vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL loop_done e=%0d c=%0d got %b want 0", e, c, done); end
                tick;
            end
        end
        vectors++; if (rom_addr !== 8'd40) begin miscompares++; $display("FAIL loop_wrap_addr got %0d want 40", rom_addr); end
        tick; tick;
        vectors++; if (left_sample !== A) begin miscompares++; $display("FAIL loop_play got %0d want %0d", left_sample, A); end
        stop = 1'b1; start = 1'b1; tick; stop = 1'b0; start = 1'b0;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL stop_busy got %b want 0", busy); end
        vectors++; if (left_sample !== 32'sd0) begin miscompares++; $display("FAIL stop_left got %0d want 0", left_sample); end
        vectors++; if (right_sample !== 32'sd0) begin miscompares++; $display("FAIL stop_right got %0d want 0", right_sample); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL stop_done got %b want 0", done); end
        tick;
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL stop_done_late got %b want 0", done); end
        loop_en = 1'b0;
        start = 1'b1; tick; start = 1'b0;
        vectors++; if (rom_addr !== 8'd40) begin miscompares++; $display("FAIL replay_addr got %0d want 40", rom_addr); end
        tick; tick;
        vectors++; if (left_sample !== A) begin miscompares++; $display("FAIL replay_left got %0d want %0d", left_sample, A); end
        vectors++; if (write_audio_out !== 1'b1) begin miscompares++; $display("FAIL replay_write got %b want 1", write_audio_out); end
        stop = 1'b1; tick; stop = 1'b0;
    endtask

    task automatic test_addr_wrap;
        rom_mem[255] = mk(1'b0, 2, 0, 2);
        rom_mem[0]   = mk(1'b1, 2, 0, 2);
        base_addr = 8'd255; loop_en = 1'b0;
        start = 1'b1; tick; start = 1'b0;
        vectors++; if (rom_addr !== 8'd255) begin miscompares++; $display("FAIL wrap_base got %0d want 255", rom_addr); end
        tick; tick; tick; tick;
        vectors++; if (rom_addr !== 8'd0) begin miscompares++; $display("FAIL wrap_next got %0d want 0", rom_addr); end
        tick; tick;
        vectors++; if (left_sample !== A) begin miscompares++; $display("FAIL wrap_left got %0d want %0d", left_sample, A); end
        tick; tick;
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL wrap_done got %b want 1", done); end
        tick;
    endtask

    task automatic test_reset_in_wait;
        rom_mem[50] = mk(1'b1, 4, 0, 2);
        base_addr = 8'd50; audio_out_allowed = 1'b1;
        start = 1'b1; tick; start = 1'b0;
        tick;
        vectors++; if (state_dbg !== 3'd2) begin miscompares++; $display("FAIL rwait_state got %0d want 2", state_dbg); end
        reset = 1'b1; tick; reset = 1'b0;
        vectors++; if (rom_addr !== 8'd0) begin miscompares++; $display("FAIL rwait_addr got %0d want 0", rom_addr); end
        vectors++; if (left_sample !== 32'sd0) begin miscompares++; $display("FAIL rwait_left got %0d want 0", left_sample); end
        vectors++; if (write_audio_out !== 1'b0) begin miscompares++; $display("FAIL rwait_write got %b want 0", write_audio_out); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rwait_busy got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rwait_done got %b want 0", done); end
        tick;
        start = 1'b1; tick; start = 1'b0;
        vectors++; if (rom_addr !== 8'd50) begin miscompares++; $display("FAIL rwait_restart_addr got %0d want 50", rom_addr); end
        tick; tick;
        vectors++; if (write_audio_out !== 1'b1) begin miscompares++; $display("FAIL rwait_first_write got %b want 1", write_audio_out); end
        vectors++; if (left_sample !== A) begin miscompares++; $display("FAIL rwait_first_left got %0d want %0d", left_sample, A); end
        stop = 1'b1; tick; stop = 1'b0;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
        audio_out_allowed = 1'b0; base_addr = 8'd0;
        for (int i = 0; i < 256; i++) rom_mem[i] = '0;
        tick;
        test_reset;
        test_single_note;
        test_two_voice;
        test_short_notes;
        test_loop_stop;
        test_addr_wrap;
        test_reset_in_wait;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
